// File: rtl/mips_sc_controller.sv
// Control FSM for the MIPS single-cycle datapath: sequences FETCH/EXEC, decodes
// the instruction in EXEC, and tracks halt, illegal and retired-instruction status.
module mips_sc_controller #(
    parameter int          FETCH_CYCLES = 1,
    parameter logic [5:0]  HALT_OPCODE  = 6'h3F,
    parameter int          CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [31:0]          instruction_bus,
    input  logic                 zer,
    input  logic                 st,
    output logic                 reg_write_en,
    output logic [1:0]           reg_write_sel,
    output logic                 pc_load_en,
    output logic [1:0]           pc_next_sel,
    output logic                 ALU_B_sel,
    output logic [2:0]           ALU_op_code,
    output logic                 mem_write_en,
    output logic                 mem_read_en,
    output logic                 mem_out_sel,
    output logic                 slt_ALU_sel,
    output logic                 jal_sel,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [2:0] WAIT_LAST = 3'(FETCH_CYCLES - 1);

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    logic [1:0]           state_q, state_d;
    logic [2:0]           wait_q, wait_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic                 halted_q, halted_d;
    logic                 illegal_q, illegal_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    assign opcode = instruction_bus[31:26];
    assign funct  = instruction_bus[5:0];

    // st is consumed by the datapath mux that slt_ALU_sel steers, not here.
    logic unused_inputs;
    assign unused_inputs = ^{st, instruction_bus[25:6]};

    logic       dec_legal;
    logic       dec_halt;
    logic       dec_rwe;
    logic [1:0] dec_rws;
    logic [1:0] dec_nps;
    logic       dec_bsel;
    logic [2:0] dec_op;
    logic       dec_mwe;
    logic       dec_mre;
    logic       dec_mos;
    logic       dec_slt;
    logic       dec_jal;

    always_comb begin
        dec_legal = 1'b0;
        dec_halt  = 1'b0;
        dec_rwe   = 1'b0;
        dec_rws   = 2'd0;
        dec_nps   = 2'd0;
        dec_bsel  = 1'b0;
        dec_op    = ALU_ADD;
        dec_mwe   = 1'b0;
        dec_mre   = 1'b0;
        dec_mos   = 1'b0;
        dec_slt   = 1'b0;
        dec_jal   = 1'b0;
        if (opcode == HALT_OPCODE) begin
            dec_halt = 1'b1;
        end else begin
            case (opcode)
                6'h00: begin
                    dec_legal = 1'b1;
                    dec_rwe   = 1'b1;
                    case (funct)
                        6'h20: dec_op = ALU_ADD;
                        6'h22: dec_op = ALU_SUB;
                        6'h24: dec_op = ALU_AND;
                        6'h25: dec_op = ALU_OR;
                        6'h2A: begin
                            dec_op  = ALU_SUB;
                            dec_slt = 1'b1;
                        end
                        6'h08: begin
                            dec_rwe = 1'b0;
                            dec_nps = 2'd3;
                        end
                        default: dec_legal = 1'b0;
                    endcase
                end
                6'h08: begin
                    dec_legal = 1'b1;
                    dec_rwe   = 1'b1;
                    dec_rws   = 2'd1;
                    dec_bsel  = 1'b1;
                end
                6'h0A: begin
                    dec_legal = 1'b1;
                    dec_rwe   = 1'b1;
                    dec_rws   = 2'd1;
                    dec_bsel  = 1'b1;
                    dec_op    = ALU_SUB;
                    dec_slt   = 1'b1;
                end
                6'h23: begin
                    dec_legal = 1'b1;
                    dec_rwe   = 1'b1;
                    dec_rws   = 2'd1;
                    dec_bsel  = 1'b1;
                    dec_mre   = 1'b1;
                    dec_mos   = 1'b1;
                end
                6'h2B: begin
                    dec_legal = 1'b1;
                    dec_bsel  = 1'b1;
                    dec_mwe   = 1'b1;
                end
                6'h04: begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_SUB;
                    dec_nps   = zer ? 2'd1 : 2'd0;
                end
                6'h02: begin
                    dec_legal = 1'b1;
                    dec_nps   = 2'd2;
                end
                6'h03: begin
                    dec_legal = 1'b1;
                    dec_nps   = 2'd2;
                    dec_rwe   = 1'b1;
                    dec_rws   = 2'd2;
                    dec_jal   = 1'b1;
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // Halt and illegal instructions leave every control at 0, freezing the PC on them.
    logic exec_active;
    assign exec_active = (state_q == S_EXEC) && dec_legal;

    assign reg_write_en  = exec_active & dec_rwe;
    assign reg_write_sel = exec_active ? dec_rws : 2'd0;
    assign pc_load_en    = exec_active;
    assign pc_next_sel   = exec_active ? dec_nps : 2'd0;
    assign ALU_B_sel     = exec_active & dec_bsel;
    assign ALU_op_code   = exec_active ? dec_op : 3'd0;
    assign mem_write_en  = exec_active & dec_mwe;
    assign mem_read_en   = exec_active & dec_mre;
    assign mem_out_sel   = exec_active & dec_mos;
    assign slt_ALU_sel   = exec_active & dec_slt;
    assign jal_sel       = exec_active & dec_jal;
    assign halted        = halted_q;
    assign illegal       = illegal_q;
    assign retired_count = retired_q;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        retired_d = retired_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                wait_d  = 3'd0;
            end
            S_FETCH: begin
                if (run) begin
                    if (wait_q == WAIT_LAST) begin
                        state_d = S_EXEC;
                        wait_d  = 3'd0;
                    end else begin
                        wait_d = wait_q + 3'd1;
                    end
                end
            end
            S_EXEC: begin
                if (dec_legal) begin
                    state_d   = S_FETCH;
                    wait_d    = 3'd0;
                    retired_d = retired_q + 1'b1;
                end else begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    if (!dec_halt) begin
                        illegal_d = 1'b1;
                    end
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= 3'd0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_mips_sc_controller.sv
// Directed-vector bench for mips_sc_controller (FETCH_CYCLES = 1): decode table,
// run stall, asynchronous reset mid-EXEC, halt and illegal handling.
module tb_mips_sc_controller;

    logic        clk;
    logic        rst;
    logic        run;
    logic [31:0] instruction_bus;
    logic        zer;
    logic        st;
    logic        reg_write_en;
    logic [1:0]  reg_write_sel;
    logic        pc_load_en;
    logic [1:0]  pc_next_sel;
    logic        ALU_B_sel;
    logic [2:0]  ALU_op_code;
    logic        mem_write_en;
    logic        mem_read_en;
    logic        mem_out_sel;
    logic        slt_ALU_sel;
    logic        jal_sel;
    logic        halted;
    logic        illegal;
    logic [31:0] retired_count;

    mips_sc_controller dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .instruction_bus (instruction_bus),
        .zer             (zer),
        .st              (st),
        .reg_write_en    (reg_write_en),
        .reg_write_sel   (reg_write_sel),
        .pc_load_en      (pc_load_en),
        .pc_next_sel     (pc_next_sel),
        .ALU_B_sel       (ALU_B_sel),
        .ALU_op_code     (ALU_op_code),
        .mem_write_en    (mem_write_en),
        .mem_read_en     (mem_read_en),
        .mem_out_sel     (mem_out_sel),
        .slt_ALU_sel     (slt_ALU_sel),
        .jal_sel         (jal_sel),
        .halted          (halted),
        .illegal         (illegal),
        .retired_count   (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {rwe, rws[1:0], pcl, nps[1:0], bsel, op[2:0], mwe, mre, mos, slt, jal}
    logic [14:0] ctrl;
    assign ctrl = {reg_write_en, reg_write_sel, pc_load_en, pc_next_sel, ALU_B_sel,
                   ALU_op_code, mem_write_en, mem_read_en, mem_out_sel, slt_ALU_sel, jal_sel};

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_ret = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH; checks the EXEC cycle, then the return to FETCH.
    task automatic run_vec(input string tag, input logic [31:0] instr, input logic z,
                           input logic [14:0] exp_ctrl);
        instruction_bus = instr;
        zer = z;
        tick();
        chk(tag, 32'(ctrl), 32'(exp_ctrl));
        tick();
        exp_ret = exp_ret + 32'd1;
        chk({tag, "_retired"}, retired_count, exp_ret);
        chk({tag, "_fetch_ctrl"}, 32'(ctrl), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b1;
        instruction_bus = 32'h00221820;
        zer = 1'b0;
        st = 1'b0;
        #1;
        chk("reset_ctrl", 32'(ctrl), 32'd0);
        chk("reset_retired", retired_count, 32'd0);
        chk("reset_flags", {30'd0, halted, illegal}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        chk("idle_ctrl", 32'(ctrl), 32'd0);
        tick();
        chk("fetch_ctrl", 32'(ctrl), 32'd0);

        run_vec("add",     32'h00221820, 1'b0, 15'b1_00_1_00_0_000_0_0_0_0_0);
        run_vec("sub",     32'h00221822, 1'b0, 15'b1_00_1_00_0_001_0_0_0_0_0);
        run_vec("and",     32'h00221824, 1'b0, 15'b1_00_1_00_0_010_0_0_0_0_0);
        run_vec("or",      32'h00221825, 1'b0, 15'b1_00_1_00_0_011_0_0_0_0_0);
        run_vec("slt",     32'h0022182A, 1'b0, 15'b1_00_1_00_0_001_0_0_0_1_0);
        run_vec("addi",    32'h20010005, 1'b0, 15'b1_01_1_00_1_000_0_0_0_0_0);
        run_vec("slti",    32'h28010005, 1'b0, 15'b1_01_1_00_1_001_0_0_0_1_0);
        run_vec("lw",      32'h8C010004, 1'b0, 15'b1_01_1_00_1_000_0_1_1_0_0);
        run_vec("sw",      32'hAC010004, 1'b0, 15'b0_00_1_00_1_000_1_0_0_0_0);
        run_vec("beq_z1",  32'h10220003, 1'b1, 15'b0_00_1_01_0_001_0_0_0_0_0);
        run_vec("beq_z0",  32'h10220003, 1'b0, 15'b0_00_1_00_0_001_0_0_0_0_0);
        run_vec("j",       32'h08000010, 1'b0, 15'b0_00_1_10_0_000_0_0_0_0_0);
        run_vec("jal",     32'h0C000010, 1'b0, 15'b1_10_1_10_0_000_0_0_0_0_1);
        run_vec("jr",      32'h03E00008, 1'b0, 15'b0_00_1_11_0_000_0_0_0_0_0);

        // Stall in FETCH: nothing may move while run is low.
        run = 1'b0;
        instruction_bus = 32'h20010005;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ctrl", 32'(ctrl), 32'd0);
        end
        chk("stall_retired", retired_count, exp_ret);
        run = 1'b1;
        tick();
        chk("stall_exec", 32'(ctrl), 32'(15'b1_01_1_00_1_000_0_0_0_0_0));
        tick();
        exp_ret = exp_ret + 32'd1;
        chk("stall_retired_after", retired_count, exp_ret);

        // Asynchronous reset in the middle of a sw EXEC cycle.
        instruction_bus = 32'hAC010004;
        tick();
        chk("sw_exec_mwe", {31'd0, mem_write_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_exec_mwe", {31'd0, mem_write_en}, 32'd0);
        chk("rst_mid_exec_retired", retired_count, 32'd0);
        exp_ret = 32'd0;
        tick();
        rst = 1'b0;
        chk("rst_idle_ctrl", 32'(ctrl), 32'd0);
        tick();
        chk("rst_fetch_ctrl", 32'(ctrl), 32'd0);
        run_vec("sw_after_rst", 32'hAC010004, 1'b0, 15'b0_00_1_00_1_000_1_0_0_0_0);

        // Halt opcode.
        instruction_bus = 32'hFC000000;
        tick();
        chk("halt_exec_ctrl", 32'(ctrl), 32'd0);
        tick();
        chk("halt_flags", {30'd0, halted, illegal}, 32'd2);
        instruction_bus = 32'h00221820;
        repeat (3) tick();
        chk("halt_stay_ctrl", 32'(ctrl), 32'd0);
        chk("halt_stay_retired", retired_count, exp_ret);
        chk("halt_stay_flags", {30'd0, halted, illegal}, 32'd2);
        rst = 1'b1;
        #1;
        chk("halt_rst_flags", {30'd0, halted, illegal}, 32'd0);
        tick();
        rst = 1'b0;
        exp_ret = 32'd0;
        tick();

        // Undecodable opcode 3Eh.
        instruction_bus = 32'hF8000000;
        tick();
        chk("ill_op_exec_ctrl", 32'(ctrl), 32'd0);
        tick();
        chk("ill_op_flags", {30'd0, halted, illegal}, 32'd3);
        rst = 1'b1;
        #1;
        chk("ill_rst_flags", {30'd0, halted, illegal}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Undecodable R-type funct.
        instruction_bus = 32'h00000000;
        tick();
        chk("ill_funct_exec_ctrl", 32'(ctrl), 32'd0);
        tick();
        chk("ill_funct_flags", {30'd0, halted, illegal}, 32'd3);
        chk("ill_funct_retired", retired_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_sc_controller.md
Name: mips_sc_controller

Overview:
- Control stage that sits directly upstream of the MIPS single-cycle datapath.
- Consumes instruction_bus, zer and st from the datapath and drives every datapath control input.
- The instruction memory has a clocked read, so each instruction is sequenced as FETCH (FETCH_CYCLES wait cycles) followed by one EXEC cycle.
- Also provides halt/illegal detection and a retired-instruction counter for the bench.

Parameters:
FETCH_CYCLES, 1, number of wait cycles before EXEC (range 1..7)
HALT_OPCODE, 6'h3F, opcode that stops the core
CNT_WIDTH, 32, width of retired_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  when low, the FSM holds in FETCH (stall); no effect in other states
instruction_bus  input  32  current instruction from the datapath
zer  input  1  ALU zero flag
st  input  1  ALU set-less-than flag
reg_write_en  output  1  register file write enable
reg_write_sel  output  2  write address select: 0 = rd, 1 = rt, 2 = r31
pc_load_en  output  1  PC load enable
pc_next_sel  output  2  next PC select: 0 = pc+4, 1 = branch target, 2 = jump label, 3 = rs (jr)
ALU_B_sel  output  1  ALU B operand: 0 = rt data, 1 = immediate
ALU_op_code  output  3  0 = ADD, 1 = SUB, 2 = AND, 3 = OR
mem_write_en  output  1  data memory write enable
mem_read_en  output  1  data memory read enable
mem_out_sel  output  1  writeback source: 0 = ALU path, 1 = memory
slt_ALU_sel  output  1  ALU path: 0 = ALU result, 1 = st
jal_sel  output  1  writeback: 0 = memory/ALU path, 1 = PC
halted  output  1  sticky, set on entering HALT
illegal  output  1  sticky, set when an undecodable instruction reaches EXEC
retired_count  output  CNT_WIDTH  number of completed instructions

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs go to 0 immediately: every enable, every select, halted, illegal and retired_count.
  - Applies at any time, including mid-EXEC and while in HALT.
- FSM states: IDLE, FETCH, EXEC, HALT.
  - IDLE: one cycle after reset release, then FETCH; the wait counter loads 0.
  - FETCH: the wait counter increments only while run = 1. When the counter reaches FETCH_CYCLES-1 with run = 1, go to EXEC. If run = 0, hold the state and the counter.
  - EXEC: lasts exactly one cycle. Legal non-halt instruction: go to FETCH and increment retired_count (wraps modulo 2^CNT_WIDTH). HALT_OPCODE: go to HALT and set halted. Undecodable: go to HALT and set both illegal and halted.
  - HALT: absorbing state; only rst leaves it.
- Outputs outside EXEC: all enables and selects are 0.
- Outputs in EXEC: decoded combinationally from instruction_bus, zer and st.
- Latency: 1 + FETCH_CYCLES cycles per instruction when run stays high.
- Decode, opcode in bits [31:26], funct in bits [5:0]. Every instruction in this list drives pc_load_en = 1.
  - R-type (opcode 0): reg_write_en = 1, reg_write_sel = 0, ALU_B_sel = 0, pc_next_sel = 0.
    - add (20h): ALU ADD.
    - sub (22h): ALU SUB.
    - and (24h): ALU AND.
    - or (25h): ALU OR.
    - slt (2Ah): ALU SUB, slt_ALU_sel = 1.
  - jr (opcode 0, funct 08h): overrides the R-type row. pc_next_sel = 3, reg_write_en = 0.
  - addi (08h): reg_write_en = 1, reg_write_sel = 1, ALU_B_sel = 1, ALU ADD.
  - slti (0Ah): same as addi, but ALU SUB and slt_ALU_sel = 1.
  - lw (23h): ALU ADD, ALU_B_sel = 1, mem_read_en = 1, mem_out_sel = 1, reg_write_en = 1, reg_write_sel = 1.
  - sw (2Bh): ALU ADD, ALU_B_sel = 1, mem_write_en = 1.
  - beq (04h): ALU SUB, ALU_B_sel = 0. pc_next_sel = 1 if zer, else 0.
  - j (02h): pc_next_sel = 2.
  - jal (03h): pc_next_sel = 2, reg_write_en = 1, reg_write_sel = 2, jal_sel = 1.
- Halt or illegal in EXEC: pc_load_en, reg_write_en and mem_write_en all stay 0, so architectural state is untouched and the PC stays on the offending instruction.
- No other opcode or funct value is legal.

Test Plan:
- Reset and idle: assert rst mid-EXEC of sw → mem_write_en drops to 0 in the same cycle. After release: 1 IDLE cycle, FETCH_CYCLES FETCH cycles, then the first EXEC; retired_count = 0.
- add $3,$1,$2 (32'h00221820) with FETCH_CYCLES = 1 → the EXEC cycle arrives 2 cycles after IDLE, with reg_write_en = 1, reg_write_sel = 0, ALU_op_code = 0, pc_load_en = 1; retired_count becomes 1.
- beq (32'h10220003) with zer = 1 → pc_next_sel = 1; with zer = 0 → pc_next_sel = 0. pc_load_en = 1 in both cases.
- jal (32'h0C000010) → reg_write_sel = 2, jal_sel = 1, pc_next_sel = 2. Then jr $31 (32'h03E00008) → pc_next_sel = 3, reg_write_en = 0.
- run held low for 5 cycles in FETCH → state and counter frozen, all enables 0; EXEC occurs FETCH_CYCLES cycles after run returns high.
- Opcode 3Fh → halted = 1, illegal = 0, no enables, stays in HALT. Opcode 3Eh → halted = 1 and illegal = 1. rst clears both.
